// File: rtl/cpu_halt_seq.sv
// Core halt/run handshake sequencer: requests a core halt, reports when clocks may be
// gated, wakes the core on wake events or SoC wire changes, and flags ack timeouts.
module cpu_halt_seq #(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        cptra_rst_b,
   input  logic        fw_halt_req,
   input  logic        wake_evt,
   input  logic [63:0] generic_input_wires,
   output logic        core_halt_req,
   input  logic        core_halt_ack,
   output logic        core_run_req,
   input  logic        core_run_ack,
   output logic        cpu_halt_status,
   input  logic        err_clr,
   output logic [1:0]  halt_err,
   output logic [1:0]  dbg_state_o
);

   localparam int CW = $clog2(ACK_TIMEOUT + 1);
   // The counter holds the number of full cycles already spent in the state, so the
   // ACK_TIMEOUT-th cycle without an ack is the one where it reads ACK_TIMEOUT-1.
   localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);
   localparam logic [CW-1:0] TO_MAX  = CW'(ACK_TIMEOUT);

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_HALT_REQ = 2'd1,
      S_HALTED   = 2'd2,
      S_RUN_REQ  = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            pend_q, pend_d;
   logic [1:0]      err_q, err_d;
   logic [63:0]     gen_q;
   logic            halt_req_q, run_req_q, status_q;
   logic            wake, timeout;
   logic [1:0]      err_set;

   always_comb begin
      wake    = wake_evt | (generic_input_wires != gen_q);
      timeout = (cnt_q == TO_LAST);
      state_d = state_q;
      pend_d  = pend_q;
      err_set = 2'b00;
      case (state_q)
         S_RUN: begin
            if (fw_halt_req) state_d = S_HALT_REQ;
         end
         S_HALT_REQ: begin
            if (wake) pend_d = 1'b1;
            if (core_halt_ack) begin
               // A wake seen anywhere in the handshake skips the gated state entirely.
               state_d = (pend_q | wake) ? S_RUN_REQ : S_HALTED;
            end else if (timeout) begin
               state_d    = S_RUN;
               err_set[0] = 1'b1;
            end
         end
         S_HALTED: begin
            if (wake) state_d = S_RUN_REQ;
         end
         default: begin
            if (core_run_ack)  state_d    = S_RUN;
            else if (timeout)  err_set[1] = 1'b1;
         end
      endcase
      if (state_d == S_RUN) pend_d = 1'b0;

      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if ((state_q == S_HALT_REQ || state_q == S_RUN_REQ) && cnt_q != TO_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end

      err_d = (err_q & ~{2{err_clr}}) | err_set;
   end

   always_ff @(posedge clk or negedge cptra_rst_b) begin
      if (!cptra_rst_b) begin
         state_q    <= S_RUN;
         cnt_q      <= '0;
         pend_q     <= 1'b0;
         err_q      <= 2'b00;
         gen_q      <= '0;
         halt_req_q <= 1'b0;
         run_req_q  <= 1'b0;
         status_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
         err_q      <= err_d;
         gen_q      <= generic_input_wires;
         halt_req_q <= (state_d == S_HALT_REQ);
         run_req_q  <= (state_d == S_RUN_REQ);
         status_q   <= (state_d == S_HALTED);
      end
   end

   assign core_halt_req   = halt_req_q;
   assign core_run_req    = run_req_q;
   assign cpu_halt_status = status_q;
   assign halt_err        = err_q;
   assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_cpu_halt_seq.sv
// Randomized and directed scoreboard bench for cpu_halt_seq with a behavioural
// model of the halt/wake handshake.
module tb_cpu_halt_seq;

   localparam int TO = 8;
   localparam int M_RUN = 0, M_HALTING = 1, M_HALTED = 2, M_WAKING = 3;

   logic        clk = 1'b0;
   logic        cptra_rst_b = 1'b0;
   logic        fw_halt_req = 1'b0;
   logic        wake_evt = 1'b0;
   logic [63:0] generic_input_wires = '0;
   logic        core_halt_req;
   logic        core_halt_ack = 1'b0;
   logic        core_run_req;
   logic        core_run_ack = 1'b0;
   logic        cpu_halt_status;
   logic        err_clr = 1'b0;
   logic [1:0]  halt_err;
   logic [1:0]  dbg_state;

   cpu_halt_seq #(.ACK_TIMEOUT(TO)) dut (
      .clk                 (clk),
      .cptra_rst_b         (cptra_rst_b),
      .fw_halt_req         (fw_halt_req),
      .wake_evt            (wake_evt),
      .generic_input_wires (generic_input_wires),
      .core_halt_req       (core_halt_req),
      .core_halt_ack       (core_halt_ack),
      .core_run_req        (core_run_req),
      .core_run_ack        (core_run_ack),
      .cpu_halt_status     (cpu_halt_status),
      .err_clr             (err_clr),
      .halt_err            (halt_err),
      .dbg_state_o         (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // reference model: abstract mode plus elapsed-cycle count
   int          m_mode = M_RUN;
   int          m_elapsed = 0;
   bit          m_pend = 1'b0;
   logic [63:0] m_prev = '0;
   logic [1:0]  m_err = 2'b00;

   logic [4:0]  exp_q[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [63:0] g = '0;

   function automatic void model_reset();
      m_mode = M_RUN; m_elapsed = 0; m_pend = 1'b0; m_prev = '0; m_err = 2'b00;
   endfunction

   function automatic logic [4:0] model_step(bit fw, bit wk, logic [63:0] gin,
                                             bit hack, bit rack, bit clr);
      bit         wake;
      logic [1:0] set;
      wake   = wk || (gin != m_prev);
      m_prev = gin;
      set    = 2'b00;
      case (m_mode)
         M_RUN: if (fw) begin m_mode = M_HALTING; m_elapsed = 0; end
         M_HALTING: begin
            m_elapsed++;
            m_pend = m_pend | wake;
            if (hack) begin
               m_mode = m_pend ? M_WAKING : M_HALTED;
               m_elapsed = 0;
            end else if (m_elapsed == TO) begin
               m_mode = M_RUN; m_pend = 1'b0; set[0] = 1'b1;
            end
         end
         M_HALTED: if (wake) begin m_mode = M_WAKING; m_elapsed = 0; end
         default: begin
            m_elapsed++;
            if (rack) begin m_mode = M_RUN; m_pend = 1'b0; end
            else if (m_elapsed == TO) set[1] = 1'b1;
         end
      endcase
      m_err = (clr ? 2'b00 : m_err) | set;
      return {m_mode == M_HALTED, m_mode == M_HALTING, m_mode == M_WAKING, m_err};
   endfunction

   // driver: one clock of stimulus, expectation queued for the monitor
   task automatic cycle(input bit fw, input bit wk, input logic [63:0] gin,
                        input bit hack, input bit rack, input bit clr);
      @(negedge clk);
      #1;
      cptra_rst_b         = 1'b1;
      fw_halt_req         = fw;
      wake_evt            = wk;
      generic_input_wires = gin;
      core_halt_ack       = hack;
      core_run_ack        = rack;
      err_clr             = clr;
      exp_q.push_back(model_step(fw, wk, gin, hack, rack, clr));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, g, 0, 0, 0);
   endtask

   // asynchronous reset mid-cycle; stays low until the next cycle() call
   task automatic apply_reset(input string tag);
      @(negedge clk);
      #1;
      cptra_rst_b = 1'b0;
      #1;
      vectors++;
      if ({cpu_halt_status, core_halt_req, core_run_req, halt_err} !== 5'b0) begin
         miscompares++;
         $display("FAIL async_reset_%s got=%b exp=00000", tag,
                  {cpu_halt_status, core_halt_req, core_run_req, halt_err});
      end
      model_reset();
      g = '0;
      fw_halt_req = 0; wake_evt = 0; core_halt_ack = 0; core_run_ack = 0; err_clr = 0;
      generic_input_wires = g;
      @(negedge clk);
      @(negedge clk);
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      logic [4:0] e, got;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = {cpu_halt_status, core_halt_req, core_run_req, halt_err};
         vectors++;
         if (got !== e) begin
            miscompares++;
            $display("FAIL outputs t=%0t got{status,hreq,rreq,err}=%b exp=%b", $time, got, e);
         end
         vectors++;
         if (core_halt_req && core_run_req) begin
            miscompares++;
            $display("FAIL req_exclusive t=%0t got both=1 exp not both", $time);
         end
      end
   end

   initial begin
      #2;
      vectors++;
      if ({cpu_halt_status, core_halt_req, core_run_req, halt_err} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_state got=%b exp=00000",
                  {cpu_halt_status, core_halt_req, core_run_req, halt_err});
      end
      @(negedge clk);

      // normal halt, wake, run handshake
      cycle(1, 0, g, 0, 0, 0);
      idle(3);
      cycle(0, 0, g, 1, 0, 0);
      idle(3);
      cycle(0, 1, g, 0, 0, 0);
      idle(2);
      cycle(0, 0, g, 0, 1, 0);
      idle(2);

      // generic wire wake on bit 37, then held
      cycle(1, 0, g, 0, 0, 0);
      cycle(0, 0, g, 1, 0, 0);
      idle(2);
      g = 64'd1 << 37;
      cycle(0, 0, g, 0, 0, 0);
      idle(2);
      cycle(0, 0, g, 0, 1, 0);
      idle(4);

      // wake during halt handshake
      cycle(1, 0, g, 0, 0, 0);
      idle(1);
      cycle(0, 1, g, 0, 0, 0);
      idle(1);
      cycle(0, 0, g, 1, 0, 0);
      idle(1);
      cycle(0, 0, g, 0, 1, 0);
      idle(2);

      // halt ack timeout, clear, set-beats-clear, ack on the last cycle
      cycle(1, 0, g, 0, 0, 0);
      idle(10);
      cycle(0, 0, g, 0, 0, 1);
      cycle(1, 0, g, 0, 0, 0);
      idle(7);
      cycle(0, 0, g, 0, 0, 1);
      idle(1);
      cycle(0, 0, g, 0, 0, 1);
      cycle(1, 0, g, 0, 0, 0);
      idle(7);
      cycle(0, 0, g, 1, 0, 0);
      idle(2);

      // run ack timeout, then late ack
      cycle(0, 1, g, 0, 0, 0);
      idle(12);
      cycle(0, 0, g, 0, 1, 0);
      idle(1);
      cycle(0, 0, g, 0, 0, 1);

      // reset while halted and while requesting run
      cycle(1, 0, g, 0, 0, 0);
      cycle(0, 0, g, 1, 0, 0);
      idle(1);
      apply_reset("halted");
      g = 64'h0000_0000_0000_0100;
      cycle(0, 0, g, 0, 0, 0);
      idle(1);
      cycle(1, 0, g, 0, 0, 0);
      cycle(0, 0, g, 1, 0, 0);
      cycle(0, 1, g, 0, 0, 0);
      idle(2);
      apply_reset("run_req");
      idle(2);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         bit fw, wk, ha, ra, cl;
         if ($urandom_range(499, 0) == 0) apply_reset("random");
         fw = ($urandom_range(7, 0) == 0);
         wk = ($urandom_range(11, 0) == 0);
         ha = ($urandom_range(5, 0) == 0);
         ra = ($urandom_range(5, 0) == 0);
         cl = ($urandom_range(15, 0) == 0);
         if ($urandom_range(11, 0) == 0) g = g ^ (64'd1 << $urandom_range(63, 0));
         cycle(fw, wk, g, ha, ra, cl);
      end

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
